// File: rtl/limn2600_bus_pkg.sv
// Shared Limn2600 word-bus definitions: transfer fields, widths and DMA state encoding.
package limn2600_bus_pkg;

  localparam int unsigned BUS_AW     = 32;
  localparam int unsigned BUS_DW     = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LEN_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } dma_state_t;

  // Initiator-side request fields held stable until the responder completes.
  typedef struct packed {
    logic              cs;
    logic              we;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
  } bus_req_t;

  typedef struct packed {
    logic              rdy;
    logic [BUS_DW-1:0] rdata;
  } bus_rsp_t;

  function automatic logic [BUS_AW-1:0] next_word(input logic [BUS_AW-1:0] a);
    return a + BUS_AW'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/limn2600_bus_watchdog.sv
// Per-transfer wait counter; expired is high once the transfer has waited TIMEOUT-1 edges.
module limn2600_bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (waiting && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // expired is a registered decode so the FSM sees it alongside the current rdy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      expired <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      expired <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/limn2600_dma.sv
// Limn2600 block-copy DMA initiator: reads a word from src, writes it to dst, len times.
module limn2600_dma
  import limn2600_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BUS_AW-1:0] src_addr,
  input  logic [BUS_AW-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  remaining,
  output logic              cs,
  output logic              we,
  output logic [BUS_AW-1:0] addr,
  output logic [BUS_DW-1:0] data_out,
  input  logic [BUS_DW-1:0] data_in,
  input  logic              rdy
);

  dma_state_t        state_q;
  bus_req_t          req_q;
  logic [BUS_AW-1:0] src_q;
  logic [BUS_AW-1:0] dst_q;
  logic [LEN_W-1:0]  rem_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic expired;
  logic waiting_c;
  logic wd_clear_c;
  logic timeout_c;
  logic stop_c;

  assign waiting_c  = req_q.cs && !rdy;
  assign wd_clear_c = !req_q.cs || rdy;

  limn2600_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear_c),
    .waiting (waiting_c),
    .expired (expired)
  );

  // Abort wins over a simultaneous timeout; a completing transfer never times out.
  assign timeout_c = !abort && !rdy && expired;
  assign stop_c    = abort || timeout_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            rem_q  <= len;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= ST_READ;
              req_q.cs   <= 1'b1;
              req_q.we   <= 1'b0;
              req_q.addr <= src_addr;
            end
          end
        end
        ST_READ: begin
          // wdata doubles as the holding register between READ and WRITE
          if (rdy) begin
            req_q.wdata <= data_in;
          end
          if (timeout_c) begin
            err_q <= 1'b1;
          end
          if (stop_c) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            req_q.cs <= 1'b0;
            req_q.we <= 1'b0;
          end else if (rdy) begin
            state_q    <= ST_WRITE;
            req_q.we   <= 1'b1;
            req_q.addr <= dst_q;
          end
        end
        ST_WRITE: begin
          if (rdy) begin
            src_q <= next_word(src_q);
            dst_q <= next_word(dst_q);
            rem_q <= rem_q - LEN_W'(1);
          end
          if (timeout_c) begin
            err_q <= 1'b1;
          end
          if (stop_c || (rdy && (rem_q == LEN_W'(1)))) begin
            state_q  <= ST_DONE;
            done_q   <= 1'b1;
            req_q.cs <= 1'b0;
            req_q.we <= 1'b0;
          end else if (rdy) begin
            state_q    <= ST_READ;
            req_q.we   <= 1'b0;
            req_q.addr <= next_word(src_q);
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign remaining = rem_q;
  assign cs        = req_q.cs;
  assign we        = req_q.we;
  assign addr      = req_q.addr;
  assign data_out  = req_q.wdata;

endmodule

// File: tb/tb_limn2600_dma.sv
// Directed bench for limn2600_dma against a small word-SRAM responder with programmable wait states.
module tb_limn2600_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, err, cs, we, rdy;
  logic [15:0] remaining;
  logic [31:0] addr, data_out, data_in;

  int n_assert = 0;
  int n_fail   = 0;

  // responder state
  int          wait_n = 0;
  logic        never_rdy = 1'b0;
  int          wcnt = 0;
  logic [31:0] mem [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;
  logic        log_clr = 1'b0;
  int          rd_cnt = 0;
  logic [31:0] rd_addr [0:3];
  int          cs_seen = 0;
  logic        chk_stable = 1'b0;
  int          instab = 0;
  logic        prev_wait = 1'b0;
  logic        prev_we = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  always #5 clk = ~clk;

  limn2600_dma #(.TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .remaining (remaining),
    .cs        (cs),
    .we        (we),
    .addr      (addr),
    .data_out  (data_out),
    .data_in   (data_in),
    .rdy       (rdy)
  );

  assign rdy     = cs && !never_rdy && (wcnt == wait_n);
  assign data_in = mem[addr[9:2]];

  always @(posedge clk) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    if (cs && we && rdy) mem[addr[9:2]] <= data_out;
    if (log_clr) begin
      rd_cnt <= 0;
    end else if (cs && !we && rdy) begin
      if (rd_cnt < 4) rd_addr[rd_cnt[1:0]] <= addr;
      rd_cnt <= rd_cnt + 1;
    end
    if (!cs || rdy) wcnt <= 0;
    else            wcnt <= wcnt + 1;
    if (cs) cs_seen <= cs_seen + 1;
    if (chk_stable && prev_wait &&
        (!cs || we !== prev_we || addr !== prev_addr || data_out !== prev_wdata))
      instab <= instab + 1;
    prev_wait  <= cs && !rdy;
    prev_we    <= we;
    prev_addr  <= addr;
    prev_wdata <= data_out;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic mem_put(input logic [7:0] idx, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Leaves the bench 1 time unit after the edge that accepted start (cycle 1).
  task automatic start_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int k;
    int cs_base;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_remaining", remaining, 0);
    check("rst_cs", cs, 0);
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_data_out", data_out, 0);
    @(negedge clk);
    rst = 1'b1;

    mem_put(8'd64, 32'hA0); mem_put(8'd65, 32'hA1);
    mem_put(8'd66, 32'hA2); mem_put(8'd67, 32'hA3);
    mem_put(8'd80, 32'hB0); mem_put(8'd81, 32'hB1); mem_put(8'd82, 32'hB2);
    mem_put(8'd112, 32'hC0); mem_put(8'd113, 32'hC1);
    mem_put(8'd114, 32'hC2); mem_put(8'd115, 32'hC3);
    mem_put(8'd177, 32'hDEAD);
    mem_put(8'd255, 32'hE0); mem_put(8'd0, 32'hE1);

    // zero-wait copy of 4 words
    wait_n = 0;
    start_cmd(32'h100, 32'h200, 16'd4);
    check("c4_busy_c1", busy, 1);
    check("c4_cs_c1", cs, 1);
    check("c4_we_c1", we, 0);
    check("c4_addr_c1", addr, 32'h100);
    wait_done(cyc);
    check("c4_done_cycle", cyc, 9);
    check("c4_remaining", remaining, 0);
    check("c4_err", err, 0);
    check("c4_busy_at_done", busy, 1);
    check("c4_w0", mem[128], 32'hA0);
    check("c4_w1", mem[129], 32'hA1);
    check("c4_w2", mem[130], 32'hA2);
    check("c4_w3", mem[131], 32'hA3);
    @(posedge clk); #1;
    check("c4_busy_after", busy, 0);
    check("c4_done_pulse", done, 0);

    // len = 0: immediate done, no bus traffic
    cs_base = cs_seen;
    start_cmd(32'h100, 32'h200, 16'd0);
    check("l0_done_c1", done, 1);
    check("l0_busy_c1", busy, 1);
    check("l0_cs_c1", cs, 0);
    @(posedge clk); #1;
    check("l0_done_c2", done, 0);
    check("l0_busy_c2", busy, 0);
    check("l0_cs_activity", cs_seen - cs_base, 0);

    // two wait states per transfer, 3 words
    wait_n = 2;
    chk_stable = 1'b1;
    start_cmd(32'h140, 32'h240, 16'd3);
    wait_done(cyc);
    chk_stable = 1'b0;
    check("ws_done_cycle", cyc, 19);
    check("ws_remaining", remaining, 0);
    check("ws_w0", mem[144], 32'hB0);
    check("ws_w1", mem[145], 32'hB1);
    check("ws_w2", mem[146], 32'hB2);
    check("ws_stable", instab, 0);
    @(posedge clk); #1;

    // responder never ready: timeout after 8 waiting edges
    never_rdy = 1'b1;
    start_cmd(32'h180, 32'h280, 16'd2);
    wait_done(cyc);
    check("to_done_cycle", cyc, 9);
    check("to_err", err, 1);
    check("to_remaining", remaining, 2);
    check("to_cs_dropped", cs, 0);
    @(posedge clk); #1;
    check("to_busy_after", busy, 0);
    check("to_err_sticky", err, 1);
    never_rdy = 1'b0;
    wait_n = 0;
    start_cmd(32'h0, 32'h0, 16'd0);
    check("to_err_cleared", err, 0);
    check("to_clear_done", done, 1);
    @(posedge clk); #1;

    // abort during the second WRITE (one wait state keeps it pending)
    wait_n = 1;
    start_cmd(32'h1C0, 32'h2C0, 16'd4);
    k = 0;
    while (!(cs === 1'b1 && we === 1'b1 && addr === 32'h2C4) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("ab_reach_w1", (k < 50) ? 32'd1 : 32'd0, 1);
    check("ab_rdy_low", rdy, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("ab_done", done, 1);
    check("ab_cs", cs, 0);
    check("ab_remaining", remaining, 3);
    check("ab_err", err, 0);
    check("ab_w0", mem[176], 32'hC0);
    check("ab_w1_untouched", mem[177], 32'hDEAD);
    @(posedge clk); #1;
    check("ab_busy_after", busy, 0);

    // asynchronous reset in the middle of a READ at the top of memory
    wait_n = 2;
    start_cmd(32'hFFFF_FFFC, 32'h300, 16'd2);
    check("ar_cs_c1", cs, 1);
    check("ar_addr_c1", addr, 32'hFFFF_FFFC);
    #2;
    rst = 1'b0;
    #1;
    check("ar_busy", busy, 0);
    check("ar_cs", cs, 0);
    check("ar_we", we, 0);
    check("ar_addr", addr, 0);
    check("ar_remaining", remaining, 0);
    check("ar_data_out", data_out, 0);
    check("ar_done", done, 0);
    check("ar_err", err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    wait_n = 0;
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
    start_cmd(32'hFFFF_FFFC, 32'h300, 16'd2);
    wait_done(cyc);
    check("wr_done_cycle", cyc, 5);
    check("wr_reads", rd_cnt, 2);
    check("wr_rd0", rd_addr[0], 32'hFFFF_FFFC);
    check("wr_rd1", rd_addr[1], 32'h0000_0000);
    check("wr_w0", mem[192], 32'hE0);
    check("wr_w1", mem[193], 32'hE1);
    @(posedge clk); #1;
    check("wr_busy_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/limn2600_dma.md
# limn2600_dma

Block-copy bus initiator for the Limn2600 SoC. Sits on the same `cs`/`we`/`rdy` word bus as the CPU, on the initiator side, and drives the SRAM (or any responder) to copy `len` 32-bit words from `src_addr` to `dst_addr`. Control comes from a pulse/level command port; a later bus arbiter multiplexes it with the CPU.

## Interface
- `TIMEOUT`, default 255: max cycles a single bus transfer may wait for `rdy` before error; must be ≥1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `start`  in  1  command strobe, sampled only in IDLE.
- `src_addr`  in  32  source byte address, latched on accepted `start`.
- `dst_addr`  in  32  destination byte address, latched on accepted `start`.
- `len`  in  16  word count, latched on accepted `start`.
- `abort`  in  1  level; cancels an active copy.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE is left.
- `done`  out  1  one-cycle completion pulse (normal, abort or error).
- `err`  out  1  sticky timeout flag; cleared by the next accepted `start`.
- `remaining`  out  16  words still to copy.
- `cs`  out  1  bus select.
- `we`  out  1  bus write enable.
- `addr`  out  32  bus byte address.
- `data_out`  out  32  write data to the responder.
- `data_in`  in  32  read data from the responder, valid when `rdy`=1.
- `rdy`  in  1  responder completion.

## Operation
- Bus rule: a transfer completes on a rising edge where `cs`=1 and `rdy`=1. The initiator holds `cs`, `we`, `addr`, `data_out` stable until then. A new transfer may start the next cycle.
- States: IDLE, READ, WRITE, DONE.
- IDLE: `start`=1 latches the command and clears `err`. If `len`=0, go to DONE with no bus traffic. Otherwise go to READ.
- READ: `cs`=1, `we`=0, `addr`=src pointer. On completion, latch `data_in` into the holding register and go to WRITE.
- WRITE: `cs`=1, `we`=1, `addr`=dst pointer, `data_out`=holding register. On completion:
  - src and dst pointers increment by 4, wrapping modulo 2^32.
  - `remaining` decrements.
  - If `remaining` reaches 0, go to DONE; otherwise go to READ.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Addresses are used as given; the low two bits are not checked or masked.
- `abort`=1 in READ or WRITE: go to DONE at the next edge and drop `cs`. The in-flight transfer is abandoned. Completed writes persist. `remaining` holds its value.
- If `abort` and a completion fall on the same edge, the completion is applied first (pointers and count update), then the block goes to DONE.
- `abort` has no effect in IDLE or DONE. `start` is ignored outside IDLE.
- Timeout: a per-transfer wait counter resets whenever a transfer starts or completes. If it reaches `TIMEOUT` with `rdy` still low, set `err` and go to DONE.
- `rst` low at any time: return to IDLE immediately. Any in-flight transfer is dropped without completing.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `remaining`=0, `cs`=0, `we`=0, `addr`=0, `data_out`=0. Holding register and pointers also reset to 0.
- Outputs are registered; `cs`/`we`/`addr` change only on clock edges.
- `start` at edge T: `cs` is high from T+1.
- With a zero-wait responder (`rdy`=`cs`), each word takes 2 cycles.
  - A copy of N≥1 words shows `done` at cycle T+1+2N and `busy` low at T+2+2N.
- `len`=0: `done` at T+1 and no `cs` activity.
- Each wait state adds one cycle to that transfer.

## Structure
- Package `limn2600_bus_pkg` holds:
  - the state enum (IDLE/READ/WRITE/DONE);
  - `BUS_AW`=32, `BUS_DW`=32, `WORD_BYTES`=4;
  - the bus-transfer field definitions, shared with the CPU and SRAM.
- One sub-module, `limn2600_bus_watchdog`: the `TIMEOUT` wait counter. Inputs: `clk`, `rst`, `clear`, `waiting`. Output: `expired`.
- Everything else is one FSM with its datapath registers.

## Test plan
- Copy len=4, src=0x100, dst=0x200, zero-wait SRAM preloaded with 0xA0..0xA3 -> 0x200..0x20C read back 0xA0..0xA3; `done` exactly 9 cycles after `start`; `remaining`=0; `err`=0.
- len=0 -> `done` pulse one cycle after `start`; `cs` never asserted.
- Responder inserts 2 wait states on every transfer, len=3 -> data correct; `done` at 1+3·2·3=19 cycles after `start`; `cs`/`addr` stable throughout every wait.
- Responder never asserts `rdy`, TIMEOUT=8 -> `err`=1 and `done` pulse 9 cycles after `start`; the next `start` clears `err`.
- `abort` raised during the second WRITE of a len=4 copy -> first word written, second not; `done` next cycle; `remaining`=3.
- `rst` low mid-READ with src=0xFFFFFFFC (wrap case) -> all outputs return to reset values asynchronously. After release, a new copy with src=0xFFFFFFFC, len=2 reads 0xFFFFFFFC then 0x00000000.
